vga_dither: RTL and testbench

//  Final pixel-clock stage between colour generation and the VGA pins.

---
 rtl/gfx_pkg.sv | 31 +++
 rtl/dither_chan.sv | 37 +++
 rtl/vga_dither.sv | 93 +++++++++
 tb/tb_vga_dither.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics helpers for the pixel-clock output stages.
//   BAYER4       : 4x4 ordered-dither matrix, 4-bit entries, indexed [y][x]
//   pix_ctl_t    : display-enable and sync bits that travel with a pixel
//   bayer_thresh : Bayer entry scaled to a D-bit threshold
package gfx_pkg;

   localparam logic [3:0] BAYER4 [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6 },
      '{4'd3,  4'd11, 4'd1,  4'd9 },
      '{4'd15, 4'd7,  4'd13, 4'd5 }
   };

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } pix_ctl_t;

   // Entry B[yi][xi] scaled so its 16 levels span the d truncated bits:
   // shifted up when d >= 4, shifted down (losing low levels) otherwise.
   function automatic logic [31:0] bayer_thresh(input logic [1:0] xi,
                                                input logic [1:0] yi,
                                                input int unsigned d);
      logic [31:0] b;
      b = {28'd0, BAYER4[yi][xi]};
      if (d >= 4) return b << (d - 4);
      else        return b >> (4 - d);
   endfunction

endpackage

// File: rtl/dither_chan.sv
// One colour channel of the dither stage.
//   clk_pix, rst_pix_n : pixel clock, synchronous active-low reset
//   thresh             : dither threshold for this pixel (0 = plain truncation)
//   pix_in             : CHANW-bit input channel
//   de_s1              : display enable delayed to match the stage-1 sum
//   pix_out            : OUTW-bit channel, registered, blanked when de_s1=0
module dither_chan #(
   parameter int CHANW = 8,
   parameter int OUTW  = 4
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   input  logic [CHANW-1:0] thresh,
   input  logic [CHANW-1:0] pix_in,
   input  logic             de_s1,
   output logic [OUTW-1:0]  pix_out
);

   localparam int D = CHANW - OUTW;

   logic [CHANW:0] sum;

   // Stage 1: widened add keeps the carry for saturation.
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) sum <= '0;
      else            sum <= {1'b0, pix_in} + {1'b0, thresh};
   end

   // Stage 2: saturate on carry, otherwise keep the top OUTW bits.
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n)      pix_out <= '0;
      else if (!de_s1)     pix_out <= '0;
      else if (sum[CHANW]) pix_out <= '1;
      else                 pix_out <= sum[CHANW-1:D];
   end

endmodule

// File: rtl/vga_dither.sv
// Final pixel-clock stage: 4x4 ordered dither from CHANW to OUTW bits,
// optional per-frame pattern rotation, syncs delayed to match, colour
// blanked outside display enable. Latency 2 clk_pix for all outputs.
//   clk_pix, rst_pix_n      : pixel clock, synchronous active-low reset
//   en                      : 1 dither, 0 plain truncation
//   sx, sy                  : signed screen position
//   frame                   : start-of-frame pulse (advances frame_cnt)
//   de, hsync, vsync        : raw display enable and syncs
//   r_in, g_in, b_in        : input colour
//   vga_hsync, vga_vsync    : delayed syncs
//   vga_r, vga_g, vga_b     : dithered colour
module vga_dither
   import gfx_pkg::*;
#(
   parameter int   CORDW     = 16,
   parameter int   CHANW     = 8,
   parameter int   OUTW      = 4,
   parameter bit   TEMPORAL  = 1'b1,
   parameter logic SYNC_IDLE = 1'b1
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   input  logic                    en,
   input  logic signed [CORDW-1:0] sx,
   input  logic signed [CORDW-1:0] sy,
   input  logic                    frame,
   input  logic                    de,
   input  logic                    hsync,
   input  logic                    vsync,
   input  logic [CHANW-1:0]        r_in,
   input  logic [CHANW-1:0]        g_in,
   input  logic [CHANW-1:0]        b_in,
   output logic                    vga_hsync,
   output logic                    vga_vsync,
   output logic [OUTW-1:0]         vga_r,
   output logic [OUTW-1:0]         vga_g,
   output logic [OUTW-1:0]         vga_b
);

   localparam int unsigned D = CHANW - OUTW;

   logic [1:0]       frame_cnt;
   logic [1:0]       fc;
   logic [1:0]       xi;
   logic [1:0]       yi;
   logic [CHANW-1:0] thresh;
   pix_ctl_t         ctl_s1;

   // Only the low two coordinate bits select the matrix entry.
   logic unused_coord;
   assign unused_coord = ^{sx[CORDW-1:2], sy[CORDW-1:2]};

   // New count takes effect the cycle after the frame pulse.
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n)  frame_cnt <= '0;
      else if (frame)  frame_cnt <= frame_cnt + 2'd1;
   end

   always_comb begin
      fc     = TEMPORAL ? frame_cnt : 2'b00;
      xi     = sx[1:0] + {fc[0], 1'b0};
      yi     = sy[1:0] + {fc[1], 1'b0};
      thresh = en ? CHANW'(bayer_thresh(xi, yi, D)) : '0;
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         ctl_s1    <= '{de: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE};
         vga_hsync <= SYNC_IDLE;
         vga_vsync <= SYNC_IDLE;
      end else begin
         ctl_s1    <= '{de: de, hsync: hsync, vsync: vsync};
         vga_hsync <= ctl_s1.hsync;
         vga_vsync <= ctl_s1.vsync;
      end
   end

   dither_chan #(.CHANW(CHANW), .OUTW(OUTW)) u_chan_r (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .thresh(thresh),
      .pix_in(r_in), .de_s1(ctl_s1.de), .pix_out(vga_r)
   );

   dither_chan #(.CHANW(CHANW), .OUTW(OUTW)) u_chan_g (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .thresh(thresh),
      .pix_in(g_in), .de_s1(ctl_s1.de), .pix_out(vga_g)
   );

   dither_chan #(.CHANW(CHANW), .OUTW(OUTW)) u_chan_b (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .thresh(thresh),
      .pix_in(b_in), .de_s1(ctl_s1.de), .pix_out(vga_b)
   );

endmodule

// File: tb/tb_vga_dither.sv
module tb_vga_dither;

   logic               clk_pix = 1'b0;
   logic               rst_pix_n;
   logic               en;
   logic signed [15:0] sx;
   logic signed [15:0] sy;
   logic               frame;
   logic               de;
   logic               hsync;
   logic               vsync;
   logic [7:0]         r_in;
   logic [7:0]         g_in;
   logic [7:0]         b_in;
   logic               vga_hsync;
   logic               vga_vsync;
   logic [3:0]         vga_r;
   logic [3:0]         vga_g;
   logic [3:0]         vga_b;

   int checks = 0;
   int errors = 0;

   // Bayer matrix written out independently for expected values.
   int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

   vga_dither #(
      .CORDW(16), .CHANW(8), .OUTW(4), .TEMPORAL(1'b1), .SYNC_IDLE(1'b1)
   ) dut (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .en(en), .sx(sx), .sy(sy),
      .frame(frame), .de(de), .hsync(hsync), .vsync(vsync),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pix(input int x, input int y, input logic [7:0] c);
      sx   = 16'(x);
      sy   = 16'(y);
      r_in = c;
      g_in = c;
      b_in = c;
   endtask

   initial begin
      int n8;
      int n9;
      int e;
      rst_pix_n = 1'b0; en = 1'b1; frame = 1'b0;
      de = 1'b1; hsync = 1'b0; vsync = 1'b0;
      pix(0, 0, 8'hFF);
      tick(); tick();
      // reset state
      check("rst_r", vga_r, 0);
      check("rst_g", vga_g, 0);
      check("rst_hs", vga_hsync, 1);
      check("rst_vs", vga_vsync, 1);
      hsync = 1'b1; vsync = 1'b1;
      rst_pix_n = 1'b1;
      tick(); tick(); tick();
      check("lat_pre_r", vga_r, 15);
      check("lat_pre_hs", vga_hsync, 1);

      // latency: edges appear after exactly two clocks
      de = 1'b0; hsync = 1'b0; vsync = 1'b0;
      tick();
      check("lat1_r", vga_r, 15);
      check("lat1_hs", vga_hsync, 1);
      check("lat1_vs", vga_vsync, 1);
      tick();
      check("lat2_r", vga_r, 0);
      check("lat2_hs", vga_hsync, 0);
      check("lat2_vs", vga_vsync, 0);
      de = 1'b1; hsync = 1'b1; vsync = 1'b1;
      tick(); tick();
      check("lat_rise_hs", vga_hsync, 1);

      // 4x4 tile, 0x88 dithered (frame_cnt still 0)
      n8 = 0; n9 = 0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            pix(x, y, 8'h88);
            tick(); tick();
            e = (8'h88 + bay[y][x]) >> 4;
            check("tile_en", vga_r, e);
            if (vga_r == 4'd9) n9++;
            if (vga_r == 4'd8) n8++;
         end
      end
      check("tile_n9", n9, 8);
      check("tile_n8", n8, 8);

      // same tile, plain truncation
      en = 1'b0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            pix(x, y, 8'h88);
            tick(); tick();
            check("tile_trunc", vga_r, 8);
         end
      end
      en = 1'b1;

      // saturation
      for (int p = 0; p < 4; p++) begin
         pix(p, 3 - p, 8'hFF); tick(); tick();
         check("sat_ff", vga_r, 15);
         pix(p, 3 - p, 8'h00); tick(); tick();
         check("sat_00", vga_r, 0);
      end
      pix(3, 3, 8'hF5); tick(); tick();
      check("sat_f5", vga_r, 15);
      check("sat_f5_b", vga_b, 15);

      // negative coordinate: sx=-1 -> xi=3, t=10
      pix(-1, 0, 8'h86); tick(); tick();
      check("neg_sx", vga_r, 9);

      // blanking with sync still passing through
      de = 1'b0; pix(1, 1, 8'hFF); hsync = 1'b0;
      tick(); tick();
      check("blank_r", vga_r, 0);
      check("blank_hs", vga_hsync, 0);
      hsync = 1'b1;
      tick(); tick();
      check("blank_hs_rise", vga_hsync, 1);
      de = 1'b1;

      // temporal: pixel in the frame-pulse cycle uses old count
      pix(0, 0, 8'h0E); frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
      check("tmp_fc0", vga_r, 0);
      tick();
      check("tmp_fc1", vga_r, 1);
      frame = 1'b1; tick(); frame = 1'b0;
      tick(); tick();
      check("tmp_fc2", vga_r, 1);
      frame = 1'b1; tick(); frame = 1'b0;
      tick(); tick();
      check("tmp_fc3", vga_r, 0);
      frame = 1'b1; tick(); frame = 1'b0;
      tick(); tick();
      check("tmp_wrap", vga_r, 0);
      frame = 1'b1; tick(); frame = 1'b0;
      tick(); tick();
      check("tmp_fc1b", vga_r, 1);

      // reset mid-line with frame_cnt=1
      pix(0, 0, 8'hFF); hsync = 1'b0;
      tick(); tick();
      check("mid_pre_r", vga_r, 15);
      rst_pix_n = 1'b0;
      tick();
      check("mid_rst_r", vga_r, 0);
      check("mid_rst_hs", vga_hsync, 1);
      rst_pix_n = 1'b1;
      tick();
      check("mid_rel1_r", vga_r, 0);
      check("mid_rel1_hs", vga_hsync, 1);
      tick();
      check("mid_rel2_r", vga_r, 15);
      check("mid_rel2_hs", vga_hsync, 0);
      pix(0, 0, 8'h0E);
      tick(); tick();
      check("mid_fc_cleared", vga_r, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
